// File: rtl/mem_access_ctrl_if.sv
// Bundle of the upstream request/response signals and the Avalon-MM master bus
// seen by mem_access_ctrl. The master modport is the controller's view.
interface mem_access_ctrl_if;
  logic        io_done;
  logic [1:0]  mode;
  logic [24:0] mem_address;
  logic [15:0] write_data;
  logic        mem_done;
  logic [15:0] read_data;
  logic        timeout_err;

  logic [24:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;

  modport master (
    input  io_done, mode, mem_address, write_data,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest,
    output mem_done, read_data, timeout_err,
    output avm_address, avm_read, avm_write, avm_writedata
  );

  modport slave (
    output io_done, mode, mem_address, write_data,
    output avm_readdata, avm_readdatavalid, avm_waitrequest,
    input  mem_done, read_data, timeout_err,
    input  avm_address, avm_read, avm_write, avm_writedata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Bridges a four-phase upstream read/write request onto a single-word Avalon-MM
// master transfer, with a per-transfer timeout and a sticky timeout flag.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_access_ctrl_if.master bus
);

  localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W    = (CNT_BITS > 10) ? CNT_BITS : 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [24:0]      addr_q;
  logic [15:0]      wdata_q;
  logic [15:0]      rdata_q;
  logic             err_q;

  logic busy;
  logic tmo_hit;
  logic load_addr;
  logic load_wdata;
  logic capture_rd;
  logic set_err;

  assign busy    = (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ);
  assign tmo_hit = busy && (tmo_cnt == CNT_LAST);

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    load_addr  = 1'b0;
    load_wdata = 1'b0;
    capture_rd = 1'b0;
    set_err    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.io_done && bus.mode == MODE_READ) begin
          load_addr  = 1'b1;
          next_state = RD_REQ;
        end else if (bus.io_done && bus.mode == MODE_WRITE) begin
          load_addr  = 1'b1;
          load_wdata = 1'b1;
          next_state = WR_REQ;
        end
      end

      // Acceptance of a read is not completion, so the timeout still fires here.
      RD_REQ: begin
        if (tmo_hit) begin
          set_err    = 1'b1;
          next_state = DONE;
        end else if (!bus.avm_waitrequest) begin
          next_state = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (bus.avm_readdatavalid) begin
          capture_rd = 1'b1;
          next_state = DONE;
        end else if (tmo_hit) begin
          set_err    = 1'b1;
          next_state = DONE;
        end
      end

      WR_REQ: begin
        if (!bus.avm_waitrequest) begin
          next_state = DONE;
        end else if (tmo_hit) begin
          set_err    = 1'b1;
          next_state = DONE;
        end
      end

      DONE: begin
        if (!bus.io_done) next_state = IDLE;
      end

      default: next_state = IDLE;
    endcase
  end

  // Counts busy cycles of the current transfer; it leaves the busy states
  // at CNT_LAST at the latest, so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  tmo_cnt <= '0;
    else if (busy) tmo_cnt <= tmo_cnt + CNT_W'(1);
    else           tmo_cnt <= '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (load_addr)  addr_q  <= bus.mem_address;
      if (load_wdata) wdata_q <= bus.write_data;
      if (capture_rd) rdata_q <= bus.avm_readdata;
      if (set_err)    err_q   <= 1'b1;
    end
  end

  // Commands decode from the state register only, so they hold steady under
  // waitrequest and drop as soon as reset forces the state to IDLE.
  assign bus.avm_read      = (state == RD_REQ);
  assign bus.avm_write     = (state == WR_REQ);
  assign bus.mem_done      = (state == DONE);
  assign bus.avm_address   = addr_q;
  assign bus.avm_writedata = wdata_q;
  assign bus.read_data     = rdata_q;
  assign bus.timeout_err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized transfers against mem_access_ctrl with a small
// slave model; expected latency and results come from a transfer-level model.
module tb_mem_access_ctrl;

  localparam int T = 8;

  logic clk = 1'b0;
  logic reset_n;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [15:0] exp_rd;
  logic        exp_err;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One upstream request served by a slave with w stall cycles and a read
  // latency of lat cycles after acceptance. Entered and left on a negedge.
  task automatic xfer(input string tag, input logic [1:0] md, input logic [24:0] addr,
                      input logic [15:0] wd, input int w, input int lat,
                      input logic [15:0] rd, input int drop_at);
    int edges     = 0;
    int cmd       = 0;
    int j         = 0;
    bit accepted  = 1'b0;
    bit bad       = 1'b0;
    bit is_rd;
    bit done_ok;
    int exp_edges;
    int exp_cmd;

    // Transfer-level model: a read needs w+1 request cycles plus lat+1 wait
    // cycles, a write needs w+1 request cycles; more than T busy cycles times out.
    is_rd = (md == 2'b01);
    if (is_rd) begin
      done_ok   = (w + lat + 2 <= T);
      exp_edges = done_ok ? (w + lat + 3) : (T + 1);
    end else begin
      done_ok   = (w + 1 <= T);
      exp_edges = done_ok ? (w + 2) : (T + 1);
    end
    exp_cmd = (w + 1 < T) ? (w + 1) : T;

    bus.io_done           = 1'b1;
    bus.mode              = md;
    bus.mem_address       = addr;
    bus.write_data        = wd;
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 16'hDEAD;

    for (int n = 1; n <= 40 && edges == 0; n++) begin
      @(negedge clk);
      if (bus.mem_done) begin
        edges = n;
      end else begin
        if (bus.avm_read || bus.avm_write) begin
          cmd++;
          if (bus.avm_address !== addr || bus.avm_read === bus.avm_write ||
              bus.avm_read !== is_rd || (!is_rd && bus.avm_writedata !== wd))
            bad = 1'b1;
          bus.avm_waitrequest   = (cmd <= w);
          if (is_rd && cmd == w + 1) accepted = 1'b1;
          bus.avm_readdatavalid = 1'($urandom_range(0, 1));
          bus.avm_readdata      = 16'($urandom);
        end else if (accepted) begin
          j++;
          bus.avm_readdatavalid = (j == lat + 1);
          bus.avm_readdata      = (j == lat + 1) ? rd : 16'($urandom);
        end else begin
          bad = 1'b1;
        end
        bus.mem_address = 25'($urandom);
        bus.write_data  = 16'($urandom);
        bus.mode        = 2'($urandom);
        if (n == drop_at) bus.io_done = 1'b0;
      end
    end

    check({tag, " edges_to_mem_done"}, 32'(edges), 32'(exp_edges));
    check({tag, " command_cycles"}, 32'(cmd), 32'(exp_cmd));
    check({tag, " command_stable"}, 32'(bad), 32'd0);

    if (is_rd && done_ok) exp_rd = rd;
    if (!done_ok) exp_err = 1'b1;
    check({tag, " read_data"}, 32'(bus.read_data), 32'(exp_rd));
    check({tag, " timeout_err"}, 32'(bus.timeout_err), 32'(exp_err));

    if (bus.io_done) begin
      repeat (2) begin
        @(negedge clk);
        check({tag, " mem_done_held"}, 32'(bus.mem_done), 32'd1);
      end
      bus.io_done = 1'b0;
    end
    @(negedge clk);
    check({tag, " mem_done_released"}, 32'(bus.mem_done), 32'd0);
    bus.avm_readdatavalid = 1'b0;
    bus.avm_waitrequest   = 1'b0;
  endtask

  task automatic noop(input string tag, input logic [1:0] md);
    bit bad = 1'b0;
    bus.io_done = 1'b1;
    bus.mode    = md;
    repeat (10) begin
      @(negedge clk);
      if (bus.avm_read || bus.avm_write || bus.mem_done) bad = 1'b1;
    end
    check(tag, 32'(bad), 32'd0);
    bus.io_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n               = 1'b0;
    bus.io_done           = 1'b0;
    bus.mode              = 2'b00;
    bus.mem_address       = '0;
    bus.write_data        = '0;
    bus.avm_readdata      = '0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_waitrequest   = 1'b0;
    exp_rd                = '0;
    exp_err               = 1'b0;

    #1;
    check("reset mem_done",      32'(bus.mem_done),      32'd0);
    check("reset avm_read",      32'(bus.avm_read),      32'd0);
    check("reset avm_write",     32'(bus.avm_write),     32'd0);
    check("reset timeout_err",   32'(bus.timeout_err),   32'd0);
    check("reset read_data",     32'(bus.read_data),     32'd0);
    check("reset avm_address",   32'(bus.avm_address),   32'd0);
    check("reset avm_writedata", 32'(bus.avm_writedata), 32'd0);

    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    xfer("rd_zero_wait", 2'b01, 25'h1ABCDE, 16'h0000, 0, 0, 16'hBEEF, 0);
    xfer("wr_4_wait",    2'b10, 25'h000123, 16'hA55A, 4, 0, 16'h0000, 0);
    noop("noop_mode_00", 2'b00);
    noop("noop_mode_11", 2'b11);
    xfer("rd_drop_in_wait",  2'b01, 25'h0F0F0F, 16'h0000, 0, 2, 16'h5A5A, 2);
    xfer("rd_last_cycle",    2'b01, 25'h1FFFFF, 16'h0000, 0, 6, 16'hC0DE, 0);
    xfer("wr_last_cycle",    2'b10, 25'h000000, 16'hFFFF, 7, 0, 16'h0000, 0);
    xfer("rd_timeout",       2'b01, 25'h000042, 16'h0000, 0, 100, 16'h1111, 0);
    xfer("rd_after_timeout", 2'b01, 25'h000043, 16'h0000, 1, 1, 16'h1234, 0);

    for (int i = 0; i < 20; i++) begin
      xfer($sformatf("rand%0d", i), ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10,
           25'($urandom), 16'($urandom), int'($urandom_range(0, 8)),
           int'($urandom_range(0, 6)), 16'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset asserted while a write is stalled.
    bus.io_done         = 1'b1;
    bus.mode            = 2'b10;
    bus.mem_address     = 25'h0ABCDE;
    bus.write_data      = 16'h1357;
    bus.avm_waitrequest = 1'b1;
    repeat (3) @(negedge clk);
    check("midwr avm_write_before", 32'(bus.avm_write), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midwr avm_write",     32'(bus.avm_write),     32'd0);
    check("midwr mem_done",      32'(bus.mem_done),      32'd0);
    check("midwr avm_address",   32'(bus.avm_address),   32'd0);
    check("midwr avm_writedata", 32'(bus.avm_writedata), 32'd0);
    check("midwr read_data",     32'(bus.read_data),     32'd0);
    check("midwr timeout_err",   32'(bus.timeout_err),   32'd0);
    exp_rd              = '0;
    exp_err             = 1'b0;
    bus.io_done         = 1'b0;
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    xfer("rd_after_reset", 2'b01, 25'h155555, 16'h0000, 2, 1, 16'h9876, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: maximum cycles a transfer may spend in RD_REQ/RD_WAIT/WR_REQ before it is abandoned.
REQ-002 clk  in  1  single clock; every flop is rising-edge.
REQ-003 reset_n  in  1  one clock; reset is asynchronous and active-low.
REQ-004 io_done  in  1  request level from the upstream I/O controller; held high until mem_done is seen.
REQ-005 mode  in  2  01 = read, 10 = write; 00 and 11 are no-ops.
REQ-006 mem_address  in  25  word address from upstream.
REQ-007 write_data  in  16  write data from upstream.
REQ-008 mem_done  out  1  registered completion flag back to upstream.
REQ-009 read_data  out  16  registered last read result, fed to the hex display path.
REQ-010 avm_address  out  25  Avalon-MM master word address.
REQ-011 avm_read, avm_write  out  1 each  Avalon-MM commands.
REQ-012 avm_writedata  out  16  Avalon-MM write data.
REQ-013 avm_readdata  in  16; avm_readdatavalid  in  1; avm_waitrequest  in  1  Avalon-MM slave responses.
REQ-014 timeout_err  out  1  sticky flag: at least one transfer timed out.

Function
REQ-015 The controller SHALL be a state machine with states IDLE, RD_REQ, RD_WAIT, WR_REQ and DONE.
REQ-016 IDLE, io_done=1, mode=01: latch mem_address into an address register, go to RD_REQ.
REQ-017 IDLE, io_done=1, mode=10: latch mem_address and write_data into registers, go to WR_REQ.
REQ-018 IDLE, io_done=1, mode 00 or 11: stay in IDLE, issue no bus cycle, leave mem_done at 0.
REQ-019 Changes on mode, mem_address or write_data after latching SHALL be ignored until the next IDLE.
REQ-020 Command outputs:
- avm_read=1 only in RD_REQ.
- avm_write=1 only in WR_REQ.
- avm_address and avm_writedata driven from the latched registers.
- All outputs registered or decoded only from state, with no combinational path from inputs.
REQ-021 Command hold: in RD_REQ or WR_REQ, with avm_waitrequest=1, all command outputs SHALL hold stable.
REQ-022 RD_REQ with avm_waitrequest=0: the read is accepted and the next state is RD_WAIT.
REQ-023 In RD_WAIT, avm_readdatavalid=1 SHALL capture avm_readdata into read_data and go to DONE.
REQ-024 avm_readdatavalid SHALL be ignored in every state except RD_WAIT.
REQ-025 WR_REQ with avm_waitrequest=0: the write is accepted and the next state is DONE.
REQ-026 In DONE, mem_done=1; DONE SHALL stay until io_done is sampled 0, then go to IDLE with mem_done=0 (four-phase handshake).
REQ-027 If io_done falls during an active transfer, the bus cycle SHALL still complete, then DONE with a single-cycle mem_done, then IDLE.
REQ-028 Zero-wait latency:
- Read: mem_done high 3 clk edges after io_done is first sampled high, with readdatavalid one cycle after acceptance.
- Write: mem_done high 2 clk edges after io_done is first sampled high.
REQ-029 Timeout counter behaviour:
- 10-bit minimum width, sized to hold TIMEOUT_CYCLES.
- Cleared in IDLE and DONE.
- Incremented every cycle in RD_REQ, RD_WAIT and WR_REQ.
REQ-030 Timeout firing: when the counter equals TIMEOUT_CYCLES-1 and the transfer does not complete in that cycle:
- Set timeout_err.
- Deassert avm_read/avm_write.
- Leave read_data unchanged.
- Go to DONE.
REQ-031 If completion and timeout happen in the same cycle, completion SHALL win and timeout_err SHALL be unchanged.
REQ-032 Once set, timeout_err SHALL clear only on reset.
REQ-033 read_data SHALL hold its value between reads and across writes.

Reset
REQ-034 While reset_n=0, asynchronously:
- State = IDLE.
- mem_done, avm_read, avm_write, timeout_err = 0.
- read_data, avm_address, avm_writedata = 0.
- Timeout counter = 0.
REQ-035 If reset_n is asserted mid-transfer, the bus command SHALL drop immediately and the transfer SHALL be abandoned with no mem_done.
REQ-036 After reset_n deasserts, the first request SHALL be sampled on the next rising edge.

Verification
REQ-037 Read, zero wait: mode=01, addr=25'h1ABCDE, io_done=1, waitrequest=0, readdatavalid+readdata=16'hBEEF one cycle after acceptance -> avm_read high for exactly 1 cycle, avm_address=25'h1ABCDE, read_data=16'hBEEF, mem_done on 3rd edge; io_done low -> IDLE next edge.
REQ-038 Write with 4 wait cycles: mode=10, addr=25'h000123, data=16'hA55A -> avm_write high for 5 cycles with stable address/data, mem_done 1 edge after waitrequest drops.
REQ-039 Timeout: TIMEOUT_CYCLES=8, read, readdatavalid never asserted -> timeout_err=1 and DONE after 8 busy cycles, read_data unchanged; second read with normal response -> timeout_err still 1.
REQ-040 No-op and abort:
- mode=00 with io_done=1 for 10 cycles -> no avm_read/avm_write, mem_done stays 0.
- io_done dropped in RD_WAIT -> mem_done pulses for 1 cycle after readdatavalid.
REQ-041 Reset mid-write: reset_n low while WR_REQ with waitrequest=1 -> avm_write=0 and mem_done=0 before the next edge, all outputs at reset values.
